// File: rtl/ama_riscv_scoreboard_pkg.sv
// Shared types for the issue scoreboard: register-file address type, default sizing,
// and a status bundle for trace/debug.
package ama_riscv_scoreboard_pkg;
    localparam int RF_AW       = 5;
    localparam int SB_MAX_OUT  = 2;
    localparam int SB_NUM_REGS = 32;

    typedef logic [RF_AW-1:0] rf_addr_t;
    localparam rf_addr_t RF_X0_ZERO = '0;

    typedef struct packed {
        logic [SB_NUM_REGS-1:0]             pending;
        logic [$clog2(SB_MAX_OUT+1)-1:0]    outstanding;
        logic                               spurious_wb;
    } sb_status_t;

    function automatic int popcount(input logic [SB_NUM_REGS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < SB_NUM_REGS; i++) n += int'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/ama_riscv_sb_hazard.sv
// Combinational RAW/WAW/capacity check of the decode-stage instruction against the
// effective (writeback-bypassed) busy vector.
module ama_riscv_sb_hazard
    import ama_riscv_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = SB_NUM_REGS,
    parameter int MAX_OUT  = SB_MAX_OUT,
    parameter int OW       = $clog2(MAX_OUT+1)
) (
    input  logic [NUM_REGS-1:0] i_eff,
    input  rf_addr_t            i_rs1,
    input  rf_addr_t            i_rs2,
    input  rf_addr_t            i_rd,
    input  logic                i_has_rs1,
    input  logic                i_has_rs2,
    input  logic                i_rd_we,
    input  logic                i_long,
    input  logic [OW-1:0]       i_outstanding,
    input  logic                i_wb_dec,
    output logic                o_hazard
);
    logic w_raw;
    logic w_waw;
    logic w_cap;

    assign w_raw = (i_has_rs1 & (i_rs1 != RF_X0_ZERO) & i_eff[i_rs1]) |
                   (i_has_rs2 & (i_rs2 != RF_X0_ZERO) & i_eff[i_rs2]);
    assign w_waw = i_rd_we & (i_rd != RF_X0_ZERO) & i_eff[i_rd];
    // A retiring op frees its slot in the same cycle, so count it as already gone.
    assign w_cap = i_long & ((32'(i_outstanding) - 32'(i_wb_dec)) == 32'(MAX_OUT));

    assign o_hazard = w_raw | w_waw | w_cap;
endmodule

// File: rtl/ama_riscv_scoreboard.sv
// Register scoreboard and issue controller: tracks in-flight long-latency destinations
// and stalls the decode stage on RAW/WAW/capacity hazards.
module ama_riscv_scoreboard
    import ama_riscv_scoreboard_pkg::*;
#(
    parameter int MAX_OUT  = SB_MAX_OUT,
    parameter int NUM_REGS = SB_NUM_REGS,
    localparam int OW      = $clog2(MAX_OUT+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_dec_valid,
    input  rf_addr_t            i_dec_rs1_addr,
    input  rf_addr_t            i_dec_rs2_addr,
    input  rf_addr_t            i_dec_rd_addr,
    input  logic                i_dec_has_rs1,
    input  logic                i_dec_has_rs2,
    input  logic                i_dec_rd_we,
    input  logic                i_dec_long,
    input  logic                i_flush,
    input  logic                i_wb_valid,
    input  rf_addr_t            i_wb_rd_addr,
    output logic                o_issue,
    output logic                o_stall,
    output logic [NUM_REGS-1:0] o_pending,
    output logic [OW-1:0]       o_outstanding,
    output logic                o_spurious_wb
);
    localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] r_pending;
    logic [OW-1:0]       r_outstanding;
    logic                r_spurious_wb;

    logic [NUM_REGS-1:0] w_clr_vec;
    logic [NUM_REGS-1:0] w_set_vec;
    logic [NUM_REGS-1:0] w_eff;
    logic                w_wb_hit;
    logic                w_x0_retire;
    logic                w_wb_dec;
    logic                w_hazard;
    logic                w_issue;
    logic                w_issue_long;

    assign w_wb_hit  = i_wb_valid & (i_wb_rd_addr != RF_X0_ZERO) & r_pending[i_wb_rd_addr];
    assign w_clr_vec = w_wb_hit ? (ONE << i_wb_rd_addr) : '0;
    // Long ops targeting x0 hold a slot but no pending bit; any surplus count is theirs.
    assign w_x0_retire = i_wb_valid & (i_wb_rd_addr == RF_X0_ZERO) &
                         (int'(r_outstanding) > popcount(SB_NUM_REGS'(r_pending)));
    assign w_wb_dec  = w_wb_hit | w_x0_retire;
    assign w_eff     = r_pending & ~w_clr_vec;

    ama_riscv_sb_hazard #(
        .NUM_REGS (NUM_REGS),
        .MAX_OUT  (MAX_OUT),
        .OW       (OW)
    ) u_hazard (
        .i_eff         (w_eff),
        .i_rs1         (i_dec_rs1_addr),
        .i_rs2         (i_dec_rs2_addr),
        .i_rd          (i_dec_rd_addr),
        .i_has_rs1     (i_dec_has_rs1),
        .i_has_rs2     (i_dec_has_rs2),
        .i_rd_we       (i_dec_rd_we),
        .i_long        (i_dec_long),
        .i_outstanding (r_outstanding),
        .i_wb_dec      (w_wb_dec),
        .o_hazard      (w_hazard)
    );

    assign o_stall      = i_dec_valid & ~i_flush & w_hazard;
    assign w_issue      = i_dec_valid & ~i_flush & ~w_hazard;
    assign o_issue      = w_issue;
    assign w_issue_long = w_issue & i_dec_long;
    assign w_set_vec    = (w_issue_long & i_dec_rd_we & (i_dec_rd_addr != RF_X0_ZERO)) ?
                          (ONE << i_dec_rd_addr) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending     <= '0;
            r_outstanding <= '0;
            r_spurious_wb <= 1'b0;
        end else begin
            r_pending     <= ((r_pending & ~w_clr_vec) | w_set_vec) & ~ONE;
            r_outstanding <= r_outstanding + OW'(w_issue_long) - OW'(w_wb_dec);
            r_spurious_wb <= r_spurious_wb | (i_wb_valid & ~w_wb_dec);
        end
    end

    assign o_pending     = r_pending;
    assign o_outstanding = r_outstanding;
    assign o_spurious_wb = r_spurious_wb;
endmodule

// File: tb/tb_ama_riscv_scoreboard.sv
// Scoreboard bench: driver pushes expected per-cycle responses from a queue-of-in-flight-ops
// model; a negedge monitor pops and compares.
module tb_ama_riscv_scoreboard;
    import ama_riscv_scoreboard_pkg::*;

    localparam int MAX_OUT = 2;
    localparam int OW      = $clog2(MAX_OUT+1);

    logic clk = 1'b0;
    logic rst;
    logic dec_valid, dec_has_rs1, dec_has_rs2, dec_rd_we, dec_long, flush, wb_valid;
    rf_addr_t dec_rs1, dec_rs2, dec_rd, wb_rd;
    logic issue, stall, spurious;
    logic [31:0] pending;
    logic [OW-1:0] outstanding;

    always #5 clk = ~clk;

    ama_riscv_scoreboard #(.MAX_OUT(MAX_OUT), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .i_dec_valid(dec_valid), .i_dec_rs1_addr(dec_rs1), .i_dec_rs2_addr(dec_rs2),
        .i_dec_rd_addr(dec_rd), .i_dec_has_rs1(dec_has_rs1), .i_dec_has_rs2(dec_has_rs2),
        .i_dec_rd_we(dec_rd_we), .i_dec_long(dec_long), .i_flush(flush),
        .i_wb_valid(wb_valid), .i_wb_rd_addr(wb_rd),
        .o_issue(issue), .o_stall(stall), .o_pending(pending),
        .o_outstanding(outstanding), .o_spurious_wb(spurious)
    );

    typedef struct {
        bit          issue;
        bit          stall;
        bit [31:0]   pending;
        int          outstanding;
        bit          spurious;
    } exp_t;

    exp_t exp_q[$];
    int   inflight[$];   // destination of every in-flight long op (0 = untracked)
    bit   m_spur;
    int   checks = 0;
    int   failures = 0;

    function automatic bit in_flight(input int r);
        foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit [31:0] model_pending();
        bit [31:0] p;
        p = '0;
        foreach (inflight[i]) if (inflight[i] != 0) p[inflight[i]] = 1'b1;
        return p;
    endfunction

    task automatic drive(input bit r, input bit v, input int rd, input int rs1, input int rs2,
                         input bit h1, input bit h2, input bit lng, input bit fl,
                         input bit wv, input int wrd);
        exp_t e;
        bit   wb_hit, wb_dec, raw, waw, cap;
        @(posedge clk); #1;
        rst = r; dec_valid = v; dec_rd = rf_addr_t'(rd); dec_rs1 = rf_addr_t'(rs1);
        dec_rs2 = rf_addr_t'(rs2); dec_has_rs1 = h1; dec_has_rs2 = h2; dec_long = lng;
        dec_rd_we = (rd != 0); flush = fl; wb_valid = wv; wb_rd = rf_addr_t'(wrd);

        wb_hit = wv && in_flight(wrd);
        wb_dec = wb_hit;
        raw = (h1 && rs1 != 0 && in_flight(rs1) && !(wb_hit && wrd == rs1)) ||
              (h2 && rs2 != 0 && in_flight(rs2) && !(wb_hit && wrd == rs2));
        waw = (rd != 0) && in_flight(rd) && !(wb_hit && wrd == rd);
        cap = lng && (inflight.size() - int'(wb_dec) == MAX_OUT);
        e.stall       = v && !fl && (raw || waw || cap);
        e.issue       = v && !fl && !e.stall;
        e.pending     = model_pending();
        e.outstanding = inflight.size();
        e.spurious    = m_spur;
        exp_q.push_back(e);

        if (r) begin
            inflight.delete();
            m_spur = 1'b0;
        end else begin
            if (wb_hit) begin
                foreach (inflight[i]) if (inflight[i] == wrd) begin
                    inflight.delete(i);
                    break;
                end
            end else if (wv) m_spur = 1'b1;
            if (e.issue && lng) inflight.push_back(rd);
        end
    endtask

    task automatic ins(input int rd, input int rs1, input int rs2, input bit lng,
                       input int wbrd, input bit fl);
        drive(0, 1, rd, rs1, rs2, rs1 != 0, rs2 != 0, lng, fl, wbrd >= 0, wbrd < 0 ? 0 : wbrd);
    endtask

    task automatic wb(input int wbrd);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, wbrd);
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue", issue, e.issue);
            chk("stall", stall, e.stall);
            chk("pending", pending, e.pending);
            chk("outstanding", outstanding, e.outstanding);
            chk("spurious_wb", spurious, e.spurious);
        end
    end

    initial begin
        int wrd, rd;
        rst = 1'b1; dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_has_rs1 = 0;
        dec_has_rs2 = 0; dec_rd_we = 0; dec_long = 0; flush = 0; wb_valid = 0; wb_rd = 0;
        m_spur = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        nop();                                  // reset state
        ins(5, 1, 0, 1, -1, 0);                 // load x5
        repeat (3) ins(6, 5, 1, 0, -1, 0);      // add x6,x5,x1 stalls
        ins(6, 5, 1, 0, 5, 0);                  // 0-cycle release on wb x5
        nop();
        ins(7, 1, 2, 1, -1, 0);                 // mult x7
        ins(8, 1, 2, 1, -1, 0);                 // mult x8
        ins(9, 2, 0, 1, -1, 0);                 // load x9: capacity stall
        ins(9, 2, 0, 1, 7, 0);                  // released by wb x7
        wb(8); wb(9); nop();
        ins(10, 1, 0, 1, -1, 0);                // load x10
        ins(10, 1, 0, 1, 10, 0);                // WAW bypassed by wb x10
        nop(); wb(10);
        ins(0, 1, 0, 1, -1, 0);                 // load x0: untracked slot
        ins(3, 0, 0, 0, -1, 0);                 // add x3,x0,x0
        wb(0); nop();
        ins(4, 1, 0, 1, -1, 0);                 // load x4
        ins(5, 4, 0, 0, -1, 1);                 // dependent add, flushed
        nop();
        wb(12); nop(); nop();                   // spurious, sticky
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // reset mid-flight
        nop();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) == 0) begin
                drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                continue;
            end
            wrd = 0;
            if ($urandom_range(99) < 40) begin
                if (inflight.size() > 0 && $urandom_range(99) < 85)
                    wrd = inflight[$urandom_range(inflight.size()-1)];
                else
                    wrd = $urandom_range(7);
            end else wrd = -1;
            rd = $urandom_range(7);
            drive(0, $urandom_range(99) < 80, rd, $urandom_range(7), $urandom_range(7),
                  $urandom_range(1), $urandom_range(1), $urandom_range(99) < 40,
                  $urandom_range(99) < 10, wrd >= 0, wrd < 0 ? 0 : wrd);
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
